// File: rtl/fft_stage_buffer.sv
// fft_stage_buffer: working-register bank for a 32-point radix-2 DIT FFT, fed by control_unit.
// Optional macro BITREV_LOAD_EN scatters input samples into bit-reversed slots on load.
module fft_stage_buffer #(
    parameter int DW     = 16,
    parameter int NPTS   = 32,
    parameter int NSTAGE = 5
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic [2:0]           stage_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NPTS*2*DW-1:0] in_data,
    input  logic [NPTS*2*DW-1:0] bf_data,
    output logic [NPTS*2*DW-1:0] stage_data,
    output logic [NPTS*2*DW-1:0] out_data,
    output logic                 out_valid,
    output logic                 seq_err
);

    localparam int SW = 2 * DW;
    localparam int FW = NPTS * SW;
    localparam logic [2:0] LAST_STAGE = 3'(NSTAGE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_next;
    logic [FW-1:0] buf_q, buf_next;
    logic [FW-1:0] out_next;
    logic          out_valid_next;
    logic          seq_err_next;

`ifdef BITREV_LOAD_EN
    localparam int AW = $clog2(NPTS);

    // Pure wiring: sample k lands in the slot whose index is k with its bits reversed.
    function automatic logic [FW-1:0] load_frame(input logic [FW-1:0] d);
        logic [FW-1:0] r;
        logic [AW-1:0] slot;
        r = '0;
        for (int k = 0; k < NPTS; k++) begin
            for (int b = 0; b < AW; b++) slot[b] = k[AW-1-b];
            r[int'(slot)*SW +: SW] = d[k*SW +: SW];
        end
        return r;
    endfunction
`else
    function automatic logic [FW-1:0] load_frame(input logic [FW-1:0] d);
        return d;
    endfunction
`endif

    // A frame can only enter at the stage boundary, and never after a sequencing fault.
    assign in_ready   = (stage_sel == LAST_STAGE) & ~seq_err;
    assign stage_data = buf_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_next     = state;
        buf_next       = buf_q;
        out_next       = out_data;
        out_valid_next = 1'b0;
        seq_err_next   = seq_err;

        if (!seq_err) begin
            if (stage_sel > LAST_STAGE) begin
                seq_err_next = 1'b1;
            end else if (stage_sel == LAST_STAGE) begin
                // Unload of the finished frame and load of the next share this edge.
                if (state == RUN) begin
                    out_next       = bf_data;
                    out_valid_next = 1'b1;
                end
                if (in_valid) begin
                    buf_next   = load_frame(in_data);
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end else if (state == RUN) begin
                buf_next = bf_data;
            end
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            // NOTE: buf_q is a flop bank, not a RAM, so it takes the reset like any other state.
            state     <= IDLE;
            buf_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state     <= state_next;
            buf_q     <= buf_next;
            out_data  <= out_next;
            out_valid <= out_valid_next;
            seq_err   <= seq_err_next;
        end
    end

endmodule
